// File: rtl/reset_seq_gen.sv
// Staged per-domain reset generator. On power-on it holds every domain in reset,
// then releases the domains in index order with a programmable gap between them.
// It also runs software-requested reset sequences on a masked subset of domains.
// scan_mode bypasses only the output mux; the sequencer keeps running underneath.
module reset_seq_gen #(
  parameter int NDOM       = 4,
  parameter int ASSERT_CYC = 16,
  parameter int GAP_W      = 8
) (
  input  logic              dclk,
  input  logic              arst_n,
  input  logic              scan_mode,
  input  logic              soft_rst_req,
  input  logic [NDOM-1:0]   soft_rst_mask,
  input  logic [GAP_W-1:0]  rel_gap,
  output logic [NDOM-1:0]   rst_out_n,
  output logic              busy,
  output logic              done
);

  localparam int CW = (ASSERT_CYC > 2) ? $clog2(ASSERT_CYC) : 1;
  localparam int IW = $clog2(NDOM);

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [NDOM-1:0]   mask_q, mask_d;
  logic [NDOM-1:0]   rst_q, rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state and output logic for the reset sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    mask_d  = mask_q;
    rst_d   = rst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // An empty mask would be a sequence that resets nothing, so it is dropped.
        if (soft_rst_req && (soft_rst_mask != '0)) begin
          mask_d  = soft_rst_mask;
          rst_d   = rst_q & ~soft_rst_mask;
          cnt_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        // The counter holds on the exit edge instead of wrapping.
        if (cnt_q == CW'(ASSERT_CYC - 1)) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (mask_q[idx_q]) rst_d[idx_q] = 1'b1;
        if (idx_q == IW'(NDOM - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (mask_q[idx_q] && (rel_gap != '0)) begin
          // rel_gap is sampled here, so changing it mid-sequence only affects later gaps.
          gap_d   = rel_gap;
          state_d = GAP;
        end else begin
          // Skipped domains cost one cycle and get no gap.
          idx_d = idx_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(1)) begin
          idx_d   = idx_q + 1'b1;
          state_d = RELEASE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; arst_n forces the full power-on sequence.
  always_ff @(posedge dclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      mask_q  <= '1;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      mask_q  <= mask_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // In scan mode the resets follow arst_n directly so the tester controls them.
  assign rst_out_n = scan_mode ? {NDOM{arst_n}} : rst_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed bench for reset_seq_gen: power-on staging, soft reset with skips,
// request while busy, async reset mid-sequence, scan bypass, empty-mask request.
module tb_reset_seq_gen;

  logic       dclk = 1'b0;
  logic       arst_n;
  logic       scan_mode;
  logic       soft_rst_req;
  logic [3:0] soft_rst_mask;
  logic [7:0] rel_gap;
  logic [3:0] rst_out_n;
  logic       busy;
  logic       done;

  int vec = 0;
  int errs = 0;

  reset_seq_gen #(.NDOM(4), .ASSERT_CYC(16), .GAP_W(8)) dut (
    .dclk(dclk), .arst_n(arst_n), .scan_mode(scan_mode),
    .soft_rst_req(soft_rst_req), .soft_rst_mask(soft_rst_mask),
    .rel_gap(rel_gap), .rst_out_n(rst_out_n), .busy(busy), .done(done)
  );

  always #5 dclk = ~dclk;

  // Checks rst_out_n/busy/done after each of edges E1..E30 following arst_n release.
  // Caller has raised arst_n at a negedge; the next posedge is E1.
  task automatic check_poweron(input string tag);
    logic [3:0] exp_r;
    for (int k = 1; k <= 30; k++) begin
      @(posedge dclk); @(negedge dclk);
      exp_r = {k >= 26, k >= 23, k >= 20, k >= 17};
      vec++;
      if (rst_out_n !== exp_r) begin
        errs++; $display("FAIL %s rst E%0d got %b exp %b", tag, k, rst_out_n, exp_r);
      end
      vec++;
      if (busy !== (k < 26)) begin
        errs++; $display("FAIL %s busy E%0d got %b exp %b", tag, k, busy, k < 26);
      end
      vec++;
      if (done !== (k == 26)) begin
        errs++; $display("FAIL %s done E%0d got %b exp %b", tag, k, done, k == 26);
      end
    end
  endtask

  // Pulses soft_rst_req for one edge; returns just after the request edge S.
  task automatic soft_req(input logic [3:0] m);
    soft_rst_mask = m;
    soft_rst_req  = 1'b1;
    @(posedge dclk); @(negedge dclk);
    soft_rst_req  = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; scan_mode = 1'b0; soft_rst_req = 1'b0;
    soft_rst_mask = '0; rel_gap = 8'd2;
    repeat (3) @(negedge dclk);
    vec++;
    if (rst_out_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
      errs++; $display("FAIL reset_state got r=%b b=%b d=%b exp r=0000 b=1 d=0",
                       rst_out_n, busy, done);
    end
  endtask

  task automatic test_poweron();
    arst_n = 1'b1;
    check_poweron("poweron");
  endtask

  task automatic test_soft_skip();
    logic [3:0] exp_r;
    rel_gap = 8'd0;
    soft_req(4'b1010);       // now after S (k=0)
    for (int k = 0; k <= 22; k++) begin
      if (k > 0) begin @(posedge dclk); @(negedge dclk); end
      exp_r = {k >= 20, 1'b1, k >= 18, 1'b1};
      vec++;
      if (rst_out_n !== exp_r) begin
        errs++; $display("FAIL soft_skip rst S+%0d got %b exp %b", k, rst_out_n, exp_r);
      end
      vec++;
      if (done !== (k == 20) || busy !== (k < 20)) begin
        errs++; $display("FAIL soft_skip busy/done S+%0d got %b/%b exp %b/%b",
                         k, busy, done, k < 20, k == 20);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    rel_gap = 8'd0;
    soft_req(4'b1111);
    if (done) ndone++;
    soft_req(4'b0011);       // busy=1 here, must be ignored
    if (done) ndone++;
    for (int k = 0; k < 40; k++) begin
      @(posedge dclk); @(negedge dclk);
      if (done) ndone++;
    end
    vec++;
    if (ndone !== 1) begin
      errs++; $display("FAIL b2b done_count got %0d exp 1", ndone);
    end
    vec++;
    if (busy !== 1'b0 || rst_out_n !== 4'b1111) begin
      errs++; $display("FAIL b2b end got b=%b r=%b exp b=0 r=1111", busy, rst_out_n);
    end
  endtask

  task automatic test_empty_mask();
    int bad = 0;
    soft_req(4'b0000);
    for (int k = 0; k < 6; k++) begin
      if (busy !== 1'b0 || done !== 1'b0 || rst_out_n !== 4'b1111) bad++;
      @(posedge dclk); @(negedge dclk);
    end
    vec++;
    if (bad !== 0) begin
      errs++; $display("FAIL empty_mask bad_cycles got %0d exp 0 (b=%b d=%b r=%b)",
                       bad, busy, done, rst_out_n);
    end
  endtask

  task automatic test_arst_mid_gap();
    rel_gap = 8'd3;
    soft_req(4'b1111);       // after S
    repeat (18) begin @(posedge dclk); @(negedge dclk); end   // after S+18: in GAP
    vec++;
    if (rst_out_n !== 4'b0001) begin
      errs++; $display("FAIL arst_gap pre got %b exp 0001", rst_out_n);
    end
    #2 arst_n = 1'b0;
    #1;
    vec++;
    if (rst_out_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
      errs++; $display("FAIL arst_gap async got r=%b b=%b d=%b exp r=0000 b=1 d=0",
                       rst_out_n, busy, done);
    end
    rel_gap = 8'd2;
    @(negedge dclk);
    arst_n = 1'b1;
    check_poweron("arst_repeat");
  endtask

  task automatic test_scan();
    #2 scan_mode = 1'b1;
    arst_n = 1'b0; #1;
    vec++;
    if (rst_out_n !== 4'b0000) begin
      errs++; $display("FAIL scan_low1 got %b exp 0000", rst_out_n);
    end
    arst_n = 1'b1; #1;
    vec++;
    if (rst_out_n !== 4'b1111) begin
      errs++; $display("FAIL scan_high got %b exp 1111", rst_out_n);
    end
    arst_n = 1'b0; #1;
    vec++;
    if (rst_out_n !== 4'b0000) begin
      errs++; $display("FAIL scan_low2 got %b exp 0000", rst_out_n);
    end
    arst_n = 1'b1; #1;
    @(negedge dclk);
    vec++;
    // FSM restarted by the reset, yet scan still forces outputs high.
    if (rst_out_n !== 4'b1111 || busy !== 1'b1) begin
      errs++; $display("FAIL scan_fsm got r=%b b=%b exp r=1111 b=1", rst_out_n, busy);
    end
  endtask

  initial begin
    test_reset();
    test_poweron();
    test_soft_skip();
    test_back_to_back();
    test_empty_mask();
    test_arst_mid_gap();
    test_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
